tw_sclk_gen: RTL and testbench

TW_SCLK_GEN -- requirements
Module: tw_sclk_gen

---
 rtl/tw_sclk_gen.sv | 154 +++++++++++++++
 tb/tb_tw_sclk_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tw_sclk_gen.sv
// SCL clock generator for a two-wire master: four quarter-period phases,
// open-drain drive, optional slave clock stretching, deferred prescale reload.
module tw_sclk_gen #(
    parameter int          CNT_W        = 16,
    parameter int unsigned DEF_PRESCALE = 249,
    parameter bit          STRETCH_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic             sync_rst,
    input  logic [CNT_W-1:0] prescale,
    input  logic             prescale_ld,
    input  logic             sclk_en,
    input  logic             sclk_in,
    output logic             sclk_oe,
    output logic [1:0]       phase,
    output logic             ph_stb,
    output logic             stretched,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STRETCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             ph_stb_q, ph_stb_d;
    logic             sync1_q, sync2_q;
    logic             sclk_s;
    logic [CNT_W-1:0] pre_eff;
    logic             cnt_end;

    assign sclk_s  = sync2_q;
    // A zero prescale would give a 1-cycle quarter; clamp to a 2-cycle minimum.
    assign pre_eff = (pre_q == '0) ? CNT_W'(1) : pre_q;
    assign cnt_end = (cnt_q == pre_eff);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ph_stb_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_d    = 2'd3;
                cnt_d      = '0;
                pend_vld_d = 1'b0;
                if (prescale_ld) pre_d = prescale;
                if (sclk_en) begin
                    state_d = ST_RUN;
                    phase_d = 2'd0;
                end
            end
            ST_RUN: begin
                if (prescale_ld) begin
                    pend_d     = prescale;
                    pend_vld_d = 1'b1;
                end
                if (STRETCH_EN && phase_q == 2'd2 && !sclk_s) begin
                    state_d = ST_STRETCH;
                end else if (cnt_end) begin
                    cnt_d = '0;
                    if (phase_q != 2'd3) begin
                        phase_d  = phase_q + 2'd1;
                        ph_stb_d = 1'b1;
                    end else begin
                        // Period boundary: commit the held prescale; a load in
                        // this same cycle stays pending for the next boundary.
                        if (pend_vld_q) pre_d = pend_q;
                        pend_vld_d = prescale_ld;
                        if (sclk_en) begin
                            phase_d  = 2'd0;
                            ph_stb_d = 1'b1;
                        end else begin
                            state_d    = ST_IDLE;
                            pend_vld_d = 1'b0;
                            if (prescale_ld) pre_d = prescale;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STRETCH: begin
                if (prescale_ld) begin
                    pend_d     = prescale;
                    pend_vld_d = 1'b1;
                end
                if (sclk_s) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 2'd3;
                cnt_d   = '0;
            end
        endcase

        if (sync_rst) begin
            state_d    = ST_IDLE;
            phase_d    = 2'd3;
            cnt_d      = '0;
            pre_d      = CNT_W'(DEF_PRESCALE);
            pend_d     = '0;
            pend_vld_d = 1'b0;
            ph_stb_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= 2'd3;
            cnt_q      <= '0;
            pre_q      <= CNT_W'(DEF_PRESCALE);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ph_stb_q   <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ph_stb_q   <= ph_stb_d;
            sync1_q    <= sync_rst ? 1'b1 : sclk_in;
            sync2_q    <= sync_rst ? 1'b1 : sync1_q;
        end
    end

    // Drive low in phases 0/1 only; STRETCH always sits in phase 2 so it releases.
    assign sclk_oe   = (state_q != ST_IDLE) && !phase_q[1];
    assign phase     = phase_q;
    assign ph_stb    = ph_stb_q;
    assign stretched = (state_q == ST_STRETCH);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tw_sclk_gen.sv
// Bench for tw_sclk_gen: two instances (stretching on/off) checked every cycle
// against a quarter-period model, plus table-driven and directed timing checks.
module tb_tw_sclk_gen;

    logic        clk = 1'b0;
    logic        async_rst, sync_rst, prescale_ld, sclk_en, sclk_in;
    logic [15:0] prescale;
    logic        oe1, stb1, str1, busy1, oe0, stb0, str0, busy0;
    logic [1:0]  ph1, ph0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tw_sclk_gen #(.CNT_W(16), .DEF_PRESCALE(249), .STRETCH_EN(1'b1)) dut (
        .clk(clk), .async_rst(async_rst), .sync_rst(sync_rst),
        .prescale(prescale), .prescale_ld(prescale_ld), .sclk_en(sclk_en),
        .sclk_in(sclk_in), .sclk_oe(oe1), .phase(ph1), .ph_stb(stb1),
        .stretched(str1), .busy(busy1));

    tw_sclk_gen #(.CNT_W(16), .DEF_PRESCALE(249), .STRETCH_EN(1'b0)) dut0 (
        .clk(clk), .async_rst(async_rst), .sync_rst(sync_rst),
        .prescale(prescale), .prescale_ld(prescale_ld), .sclk_en(sclk_en),
        .sclk_in(sclk_in), .sclk_oe(oe0), .phase(ph0), .ph_stb(stb0),
        .stretched(str0), .busy(busy0));

    // Reference: "elapsed" counts cycles spent in the current quarter.
    typedef struct {
        bit run;
        bit str;
        int ph;
        int elapsed;
        int pre;
        int pend;
        bit pvld;
        bit s1;
        bit s2;
        bit stb;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t mreset();
        mdl_t m;
        m.run = 0; m.str = 0; m.ph = 3; m.elapsed = 0; m.pre = 249;
        m.pend = 0; m.pvld = 0; m.s1 = 1; m.s2 = 1; m.stb = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit srst, bit ld, int pv, bit en, bit sin, bit sen);
        mdl_t n;
        int   qlen;
        int   np;
        if (srst) return mreset();
        n = m;
        n.s1 = sin; n.s2 = m.s1; n.stb = 0;
        qlen = (m.pre == 0) ? 2 : m.pre + 1;
        np   = m.pvld ? m.pend : m.pre;
        if (!m.run) begin
            if (ld) n.pre = pv;
            if (en) begin n.run = 1; n.ph = 0; n.elapsed = 0; end
        end else begin
            if (ld) begin n.pend = pv; n.pvld = 1; end
            if (m.str) begin
                if (m.s2) begin n.str = 0; n.elapsed = 0; end
            end else if (sen && m.ph == 2 && !m.s2) begin
                n.str = 1;
            end else if (m.elapsed + 1 < qlen) begin
                n.elapsed = m.elapsed + 1;
            end else begin
                n.elapsed = 0;
                if (m.ph < 3) begin
                    n.ph = m.ph + 1; n.stb = 1;
                end else if (en) begin
                    n.ph = 0; n.stb = 1; n.pre = np; n.pvld = ld;
                end else begin
                    n.run = 0; n.pre = ld ? pv : np; n.pvld = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] mexp(mdl_t m);
        return {m.run && m.ph < 2, 2'(m.ph), m.stb, m.str, m.run};
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: compare both DUTs with the model mid-cycle, then advance the model.
    task automatic cyc();
        @(negedge clk);
        chk("model_stretch_on",  int'({oe1, ph1, stb1, str1, busy1}), int'(mexp(m1)));
        chk("model_stretch_off", int'({oe0, ph0, stb0, str0, busy0}), int'(mexp(m0)));
        @(posedge clk);
        if (!async_rst) begin
            m1 = mreset(); m0 = mreset();
        end else begin
            m1 = mstep(m1, sync_rst, prescale_ld, int'(prescale), sclk_en, sclk_in, 1'b1);
            m0 = mstep(m0, sync_rst, prescale_ld, int'(prescale), sclk_en, sclk_in, 1'b0);
        end
        #1;
    endtask

    task automatic load(input int pv);
        prescale = 16'(pv); prescale_ld = 1'b1;
        cyc();
        prescale_ld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy1 || busy0) && n < 3000) begin n++; cyc(); end
        chk("idle_reached", int'(busy1 | busy0), 0);
    endtask

    task automatic meas(output int lo, output int hi);
        lo = 0; hi = 0;
        while (oe1 === 1'b1 && lo < 2000) begin lo++; cyc(); end
        while (oe1 === 1'b0 && busy1 && hi < 2000) begin hi++; cyc(); end
    endtask

    typedef struct {
        int pv;
        int exp_lo;
        int exp_hi;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lo, hi, lo2, hi2, n, s_cnt, post, s0, hi0;
        bit seen, d0done;

        vecs[0] = '{3, 8, 8};
        vecs[1] = '{0, 4, 4};
        vecs[2] = '{1, 4, 4};
        vecs[3] = '{7, 16, 16};
        vecs[4] = '{5, 12, 12};

        async_rst = 1'b0; sync_rst = 1'b0; prescale = '0; prescale_ld = 1'b0;
        sclk_en = 1'b0; sclk_in = 1'b1;
        m1 = mreset(); m0 = mreset();
        cyc(); cyc();
        async_rst = 1'b1;
        cyc();
        chk("reset_outputs", int'({oe1, ph1, stb1, str1, busy1}), int'(6'b0_11_0_0_0));

        // Half-period lengths for several prescales, including the zero clamp.
        foreach (vecs[i]) begin
            load(vecs[i].pv);
            sclk_en = 1'b1;
            cyc();
            meas(lo, hi);
            sclk_en = 1'b0;
            wait_idle();
            chk($sformatf("low_half_pre%0d", vecs[i].pv), lo, vecs[i].exp_lo);
            chk($sformatf("high_half_pre%0d", vecs[i].pv), hi, vecs[i].exp_hi);
        end

        // Enable dropped at the start of phase 0: full period then idle.
        load(3);
        sclk_en = 1'b1;
        cyc();
        sclk_en = 1'b0;
        n = 0;
        while (busy1 && n < 100) begin n++; cyc(); end
        chk("en_drop_busy_cycles", n, 16);
        chk("en_drop_idle_out", int'({oe1, ph1}), int'(3'b0_11));

        // Load 7 during phase 1: current period 16, next 32.
        load(3);
        sclk_en = 1'b1;
        cyc();
        repeat (4) cyc();
        prescale = 16'd7; prescale_ld = 1'b1;
        cyc();
        prescale_ld = 1'b0;
        meas(lo, hi);
        meas(lo2, hi2);
        sclk_en = 1'b0;
        wait_idle();
        chk("period_before_reload", 5 + lo + hi, 16);
        chk("period_after_reload", lo2 + hi2, 32);

        // Slave holds SCL low for 20 cycles from phase 2 start.
        load(3);
        sclk_en = 1'b1; sclk_in = 1'b1;
        cyc();
        n = 0;
        while (ph1 != 2'd2 && n < 100) begin n++; cyc(); end
        s_cnt = 0; post = 0; s0 = 0; hi0 = 0; seen = 0; d0done = 0;
        for (int k = 0; k < 31; k++) begin
            if (k == 0) sclk_in = 1'b0;
            if (k == 20) sclk_in = 1'b1;
            if (str1) begin s_cnt++; seen = 1; end
            if (seen && !str1 && ph1 == 2'd2) post++;
            if (str0) s0++;
            if (!d0done) begin
                if (!oe0) hi0++;
                else d0done = 1;
            end
            cyc();
        end
        sclk_en = 1'b0;
        wait_idle();
        chk("stretch_cycles", s_cnt, 20);
        chk("phase2_after_release", post, 4);
        chk("nostretch_flag", s0, 0);
        chk("nostretch_high_half", hi0, 8);

        // Async reset in phase 1, then default prescale must be back.
        load(3);
        sclk_en = 1'b1;
        cyc();
        repeat (5) cyc();
        chk("in_phase1", int'(ph1), 1);
        #1 async_rst = 1'b0;
        #1;
        chk("async_rst_outputs", int'({oe1, ph1, stb1, str1, busy1}), int'(6'b0_11_0_0_0));
        m1 = mreset(); m0 = mreset();
        sclk_en = 1'b0;
        cyc();
        async_rst = 1'b1;
        sclk_en = 1'b1;
        cyc();
        meas(lo, hi);
        sclk_en = 1'b0;
        chk("default_prescale_low_half", lo, 500);
        wait_idle();

        // Randomised traffic against the model.
        sclk_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) sclk_en = ~sclk_en;
            if ($urandom_range(0, 29) == 0) sclk_in = ~sclk_in;
            prescale_ld = ($urandom_range(0, 39) == 0);
            prescale    = 16'($urandom_range(0, 4));
            sync_rst    = ($urandom_range(0, 299) == 0);
            cyc();
        end
        sync_rst = 1'b0; prescale_ld = 1'b0; sclk_en = 1'b0; sclk_in = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
